snake_cmd_writer: RTL



---
 rtl/snake_cmd_writer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/snake_cmd_writer.sv
// Pushbutton to snake command bridge: debounce, queue, Avalon-MM write.
// Optional auto-repeat of a held key: define SNAKE_CMD_AUTOREPEAT_EN.
module snake_cmd_writer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4,
  parameter int CMD_ADDR        = 0,
  parameter int ADDR_W          = 4,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  key_n,
  output logic [ADDR_W-1:0]           avm_address,
  output logic                        avm_write,
  output logic [31:0]                 avm_writedata,
  input  logic                        avm_waitrequest,
  output logic [2:0]                  last_cmd,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  drop_count
);

  localparam int LW = $clog2(FIFO_DEPTH);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DLIM = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW:0] FULL_LVL = (LW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR = ADDR_W'(CMD_ADDR);

  typedef enum logic {IDLE, WRITE} st_t;

  logic [3:0]         sync1_q, sync2_q;
  logic [3:0]         deb_q, deb_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic [3:0]         press;
  logic [2:0]         enc_code;

  logic               push;
  logic [2:0]         push_code;
  logic               pop;
  logic               full, empty;
  logic               push_ok, drop;
  logic [2:0]         head;

  logic [2:0]         mem_q [FIFO_DEPTH];
  logic [LW:0]        wp_q, rp_q;
  logic [7:0]         drop_q;

  st_t                state_q, state_d;
  logic               write_q, write_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [2:0]         last_q, last_d;
  logic [7:0]         seq_q, seq_d;

  // Key lines are asynchronous and active-low; sync resets to released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      deb_q   <= 4'hF;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    press = '0;
    for (int k = 0; k < 4; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == DLIM) begin
          deb_d[k] = ~deb_q[k];
          press[k] = deb_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end
  end

  // Highest key index wins when presses coincide.
  always_comb begin
    enc_code = 3'd0;
    priority case (1'b1)
      press[3]: enc_code = 3'd4;
      press[2]: enc_code = 3'd3;
      press[1]: enc_code = 3'd2;
      press[0]: enc_code = 3'd1;
      default:  enc_code = 3'd0;
    endcase
  end

`ifdef SNAKE_CMD_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ?
                      $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RLIM = RW'(REPEAT_CYCLES - 1);

  logic [1:0]    rsel_q, rsel_d;
  logic          ract_q, ract_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rep_push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsel_q <= '0;
      ract_q <= 1'b0;
      rcnt_q <= '0;
    end else begin
      rsel_q <= rsel_d;
      ract_q <= ract_d;
      rcnt_q <= rcnt_d;
    end
  end

  always_comb begin
    rsel_d   = rsel_q;
    ract_d   = ract_q;
    rcnt_d   = rcnt_q;
    rep_push = 1'b0;
    if (|press) begin
      rsel_d = 2'(enc_code - 3'd1);
      ract_d = 1'b1;
      rcnt_d = '0;
    end else if (ract_q && deb_q[rsel_q]) begin
      ract_d = 1'b0;
      rcnt_d = '0;
    end else if (ract_q) begin
      if (rcnt_q == RLIM) begin
        rep_push = 1'b1;
        rcnt_d   = '0;
      end else begin
        rcnt_d = rcnt_q + RW'(1);
      end
    end
  end

  assign push      = (|press) | rep_push;
  assign push_code = (|press) ? enc_code : {1'b0, rsel_q} + 3'd1;
`else
  assign push      = |press;
  assign push_code = enc_code;
`endif

  assign fifo_level = wp_q - rp_q;
  assign full       = (fifo_level == FULL_LVL);
  assign empty      = (fifo_level == '0);
  assign head       = mem_q[rp_q[LW-1:0]];
  assign pop        = (state_q == WRITE) && !avm_waitrequest;
  assign push_ok    = push && (!full || pop);
  assign drop       = push && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      drop_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wp_q[LW-1:0]] <= push_code;
        wp_q <= wp_q + (LW+1)'(1);
      end
      if (pop) rp_q <= rp_q + (LW+1)'(1);
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      wdata_q <= '0;
      last_q  <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      seq_q   <= seq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = WRITE;
      WRITE:   if (!avm_waitrequest) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Head stays put during WRITE, so it names the in-flight command.
  always_comb begin
    write_d = write_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    seq_d   = seq_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          write_d = 1'b1;
          wdata_d = {16'h0, seq_q, 5'b0, head};
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          write_d = 1'b0;
          last_d  = head;
          seq_d   = seq_q + 8'd1;
        end
      end
      default: write_d = 1'b0;
    endcase
  end

  assign avm_address   = ADDR;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;
  assign last_cmd      = last_q;
  assign drop_count    = drop_q;

endmodule
